// File: rtl/disp_pkg.sv
// Shared display types, constants and the active-low 7-segment encoder used by the
// display scheduler and the downstream segment driver.
package disp_pkg;

  typedef logic [3:0][3:0] bcd4_t;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [3:0] AN_OFF       = 4'b1111;

  typedef enum logic {IDLE, SHOW} state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low; nibbles A-F render dark.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/disp_scan.sv
// Digit scan timebase: slot counter, digit rotation, frame boundary pulse and the
// optional anode blanking window (enabled by defining DISP_SCHED_BLANK_EN).
module disp_scan #(
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] digit_idx,
  output logic       frame_end,
  output logic       blank
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef DISP_SCHED_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  logic [CW-1:0] slot_cnt;
  logic          slot_last;

  assign slot_last = (slot_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_last) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CW'(1);
    end
  end

  assign frame_end = slot_last && (digit_idx == 2'd3);
  assign blank     = BLANK_EN && (slot_cnt < CW'(BLANK_CYCLES));

endmodule

// File: rtl/disp_sched.sv
// Frame-coherent display owner arbitration (fixed priority, minimum dwell) and digit
// scan decode. Define DISP_SCHED_BLANK_EN to blank anodes at the start of every slot.
module disp_sched
  import disp_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 256,
  parameter int MIN_DWELL    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*16-1:0] req_data,
  output logic [N_REQ-1:0]    grant,
  output logic [3:0]          an,
  output logic [3:0]          digit_val,
  output logic [1:0]          digit_idx,
  output logic                frame_end
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(MIN_DWELL + 2);

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [DW-1:0] dwell, dwell_n;
  bcd4_t         snapshot, snapshot_n;
  bcd4_t         req_words [N_REQ];
  logic          blank;
  logic          pend_any;
  logic [IW-1:0] pend_idx;

  disp_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .digit_idx (digit_idx),
    .frame_end (frame_end),
    .blank     (blank)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign req_words[g] = req_data[16*g +: 16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      dwell    <= '0;
      snapshot <= {BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE};
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      dwell    <= dwell_n;
      snapshot <= snapshot_n;
    end
  end

  always_comb begin
    pend_any   = |req;
    pend_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) pend_idx = IW'(i);
    end
    state_n    = state;
    owner_n    = owner;
    dwell_n    = dwell;
    snapshot_n = snapshot;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (pend_any) begin
            state_n = SHOW;
            owner_n = pend_idx;
            dwell_n = '0;
          end
        end
        SHOW: begin
          if (!req[owner]) begin
            // Owner has let go: hand over immediately regardless of dwell.
            dwell_n = '0;
            if (pend_any) owner_n = pend_idx;
            else          state_n = IDLE;
          end else if ((dwell == DW'(MIN_DWELL)) && (pend_idx < owner)) begin
            owner_n = pend_idx;
            dwell_n = '0;
          end else if (dwell != DW'(MIN_DWELL)) begin
            dwell_n = dwell + DW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
      // Refresh the displayed word every frame, even when the owner is retained.
      snapshot_n = (state_n == SHOW) ? req_words[owner_n]
                                     : {BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE, BLANK_NIBBLE};
    end
  end

  always_comb begin
    grant     = '0;
    an        = AN_OFF;
    digit_val = BLANK_NIBBLE;
    if (state == SHOW) begin
      grant[owner] = 1'b1;
      digit_val    = snapshot[digit_idx];
      if (!blank) an = ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Randomized bench for disp_sched against a cycle-level behavioural model of the
// scan timebase and the frame-boundary ownership rules.
module tb_disp_sched;

  localparam int N_REQ        = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int MIN_DWELL    = 2;

`ifdef DISP_SCHED_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*16-1:0] req_data = '0;
  logic [N_REQ-1:0]    grant;
  logic [3:0]          an;
  logic [3:0]          digit_val;
  logic [1:0]          digit_idx;
  logic                frame_end;

  int checks = 0;
  int errors = 0;

  // Model: owner = -1 means nobody owns the display.
  int          m_slot, m_digit, m_owner, m_dwell;
  logic [15:0] m_snap;

  disp_sched #(
    .N_REQ        (N_REQ),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .MIN_DWELL    (MIN_DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .an        (an),
    .digit_val (digit_val),
    .digit_idx (digit_idx),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot  = 0;
    m_digit = 0;
    m_owner = -1;
    m_dwell = 0;
    m_snap  = 16'hFFFF;
  endtask

  function automatic int lowest_req();
    for (int i = 0; i < N_REQ; i++) if (req[i]) return i;
    return -1;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_tick();
    int best;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_slot == SCAN_DIV - 1 && m_digit == 3) begin
      best = lowest_req();
      if (m_owner < 0 || !req[m_owner]) begin
        m_owner = best;
        m_dwell = 0;
      end else if (m_dwell == MIN_DWELL && best < m_owner) begin
        m_owner = best;
        m_dwell = 0;
      end else begin
        m_dwell = (m_dwell + 1 > MIN_DWELL) ? MIN_DWELL : m_dwell + 1;
      end
      m_snap = (m_owner < 0) ? 16'hFFFF : req_data[16*m_owner +: 16];
    end
    if (m_slot == SCAN_DIV - 1) begin
      m_slot  = 0;
      m_digit = (m_digit + 1) % 4;
    end else begin
      m_slot++;
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] exp_an, exp_val, exp_grant;
    exp_grant = '0;
    exp_an    = 4'b1111;
    exp_val   = 4'hF;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_val = m_snap[4*m_digit +: 4];
      if (!(BLANK_EN && m_slot < BLANK_CYCLES)) exp_an = ~(4'b0001 << m_digit);
    end
    check("grant", 32'(grant), 32'(exp_grant));
    check("an", 32'(an), 32'(exp_an));
    check("digit_val", 32'(digit_val), 32'(exp_val));
    check("digit_idx", 32'(digit_idx), 32'(m_digit));
    check("frame_end", 32'(frame_end), 32'(m_slot == SCAN_DIV - 1 && m_digit == 3));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_tick();
      @(negedge clk);
      compare_outputs();
    end
  endtask

  task automatic set_req(input int idx, input logic on, input logic [15:0] word);
    req[idx] = on;
    req_data[16*idx +: 16] = word;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    model_reset();
    compare_outputs();
    rst = 1'b0;
    step(96);                      // idle for three frames
    set_req(2, 1'b1, 16'h0300);
    step(40);
    set_req(0, 1'b1, 16'h0100);    // must wait out the dwell of owner 2
    step(130);
    set_req(0, 1'b0, 16'h0100);
    set_req(2, 1'b0, 16'h0300);
    set_req(1, 1'b1, 16'h0100);
    step(40);
    set_req(3, 1'b1, 16'h4321);    // lower priority never preempts
    step(100);
    set_req(1, 1'b1, 16'h0200);    // data change mid-frame
    step(20);
    set_req(1, 1'b0, 16'h0200);    // owner drops mid-frame
    step(60);
    rst = 1'b1;                    // reset pulse while showing
    step(1);
    rst = 1'b0;
    step(50);
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 47) == 0) begin
        int b;
        b = $urandom_range(0, N_REQ - 1);
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 19) == 0)
        req_data[16*$urandom_range(0, N_REQ - 1) +: 16] = 16'($urandom);
      rst = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    rst = 1'b0;
    step(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
# disp_sched

Time-shared controller for the 4-digit 7-segment display. Up to N_REQ requesters (vending FSM amount, error/status, test pattern, …) each present a 4-digit BCD word and a request. The block arbitrates ownership with fixed priority and minimum dwell, then drives the digit scan (anode rotation plus current nibble) into the shared 7-segment encoder. Frame-coherent: ownership and displayed data change only at frame boundaries, so digits never tear.

## Interface
- N_REQ, 4: number of requesters, 2..8; index 0 is highest priority.
- SCAN_DIV, 16384: clk cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 256: anode-off cycles at the start of each slot (only with blanking enabled).
- MIN_DWELL, 8: frames an owner keeps the display before a higher priority may preempt; 0 is legal.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- req  in  N_REQ  per-requester display request, level
- req_data  in  N_REQ*16  per-requester BCD word; requester i at [16i+15:16i]; nibble 3 = leftmost digit
- grant  out  N_REQ  one-hot current owner; all-zero when idle
- an  out  4  anode enables, active-low
- digit_val  out  4  nibble for the active digit; 4'hF = blank
- digit_idx  out  2  active digit, 0 = rightmost
- frame_end  out  1  one-cycle pulse on the last cycle of digit 3's slot

## Operation
- Scan runs continuously, including when idle. slot_cnt counts 0..SCAN_DIV-1. At the wrap, digit_idx increments 0→1→2→3→0.
- frame_end = (slot_cnt == SCAN_DIV-1) && (digit_idx == 3).
- States:
  - IDLE: grant = 0, an = 1111, digit_val = F.
  - SHOW: grant one-hot, snapshot displayed.
- All arbitration decisions are evaluated only on frame_end cycles.
- IDLE→SHOW: if any req is high, grant the lowest index.
- SHOW, owner req low: grant the lowest pending index, ignoring dwell. If none is pending, go to IDLE.
- SHOW, owner req high: preempt only if dwell == MIN_DWELL and a lower-index req is high. Lower-priority requests never preempt.
- On every SHOW frame_end, including when the owner is retained, snapshot ← new owner's req_data.
- dwell_cnt:
  - cleared on an owner change;
  - increments on each frame_end while the owner is retained;
  - saturates at MIN_DWELL.
- Display mapping:
  - an = one-cold at digit_idx.
  - digit_val = snapshot nibble[digit_idx].
  - Nibbles A–F pass through unchanged; the encoder blanks them.
- Owner dropping req mid-frame: the current frame completes from the snapshot.

## Timing
- Reset values: slot_cnt 0, digit_idx 0, state IDLE, grant 0, dwell 0, snapshot 16'hFFFF, an 1111, digit_val F, frame_end 0.
- an, digit_val and digit_idx are combinational decodes of registered state, with zero added latency.
- A decision made on a frame_end cycle is visible in grant, an and digit_val on the next cycle, which is slot 0 of the new frame.
- Worst-case request-to-grant latency from IDLE: 4*SCAN_DIV cycles.
- Preemption latency: at most (MIN_DWELL+1) frames after the owner's grant.
- rst asserted mid-operation: every register holds its reset value on the next edge. rst overrides any coincident frame_end.

## Configuration
- DISP_SCHED_BLANK_EN defined: an = 1111 while slot_cnt < BLANK_CYCLES in every slot (ghosting suppression). digit_val is unaffected.
- Undefined: anodes are active for the full slot; BLANK_CYCLES is ignored.

## Structure
- Package disp_pkg holds:
  - typedef bcd4_t (logic [3:0][3:0]);
  - constants BLANK_NIBBLE = 4'hF and AN_OFF = 4'b1111;
  - state enum {IDLE, SHOW};
  - the shared active-low 7-segment encode function.
- Sub-module disp_scan contains slot_cnt, digit_idx, frame_end and blank-window generation.
- disp_sched top contains arbitration, dwell and snapshot.

## Test plan
All tests use SCAN_DIV=8, BLANK_CYCLES=2, MIN_DWELL=2, N_REQ=4.
- Reset, no req for 3 frames -> an=1111, grant=0, digit_val=F throughout; frame_end pulses every 32 cycles.
- req[2]=1, data 16'h0300, raised at cycle 1 -> grant=0100 on the cycle after the first frame_end. digit_val sequence 0,0,3,0 with an 1110,1101,1011,0111.
- Owner 2 held, req[0]=1 with 16'h0100 -> grant stays 0100 for 2 more frames, then switches to 0001 at that frame_end. Display shows 0100.
- Owner 1 held, req[3]=1 -> req[3] never granted. Drop req[1] mid-frame -> 1000 granted at the next frame_end; the old frame finishes intact.
- Owner data changes 16'h0100→16'h0200 during slot 1 -> digit 2 still shows 1 until after the next frame_end.
- With DISP_SCHED_BLANK_EN, an=1111 for the first 2 cycles of every slot; without it, an is never 1111 while in SHOW. rst pulse mid-SHOW -> all reset values on the next cycle.
